div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
Multi-cycle sequencer for the M-extension divide/remainder ops (DIV, DIVU, REM, REMU), which the single-cycle ALU does not implement. It sits beside the ALU in the execute stage and latches operands on request. It runs a radix-2 restoring division, one quotient bit per cycle, and stalls the pipeline until the result is ready. It drives the same style of combinational stall as the ALU multiply stall, and the stall is ORed into the global stall by the top level.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
CLK  input  1  clock, rising edge
nrst  input  1  synchronous active-low reset
flush  input  1  pipeline flush; synchronous abort of any operation
load_hazard  input  1  when high, a start in IDLE is not accepted (operands not yet valid)
start  input  1  execute-stage instruction is a divide op; held high until done
div_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled only at accept
op_a  input  XLEN  dividend; sampled only at accept
op_b  input  XLEN  divisor; sampled only at accept
res  output  XLEN  registered result; valid while done=1
busy  output  1  high in CALC and FIX
done  output  1  one-cycle result-valid pulse (state DONE)
div_stall  output  1  combinational: start & ~done

Behaviour:
- Reset (nrst=0 at a clock edge) takes effect from any state, including mid-operation. It sets state=IDLE, res=0, busy=0, done=0, and clears the counter and remainder/quotient registers.
- State IDLE: accept when start=1, load_hazard=0, flush=0. On accept:
  - latch div_op and the sign flags; signed flags apply only for DIV/REM.
  - latch the magnitudes |op_a| and |op_b|; these are the raw values for unsigned ops.
  - Divide by zero (op_b==0): res = all-ones for DIV/DIVU, res = op_a for REM/REMU. Next state DONE.
  - Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF): res = 0x80000000 for DIV, res = 0 for REM. Next state DONE.
  - Otherwise: rem=0, quo=|op_a|, cnt=XLEN-1. Next state CALC.
- State CALC, each cycle:
  - trial = {rem[XLEN-1:0], quo[XLEN-1]} - {1'b0, |b|}, computed at XLEN+1 bits.
  - If trial is non-negative: rem = trial, and shift 1 into quo LSB.
  - Else: rem = the shifted value, and shift 0 into quo LSB.
  - If cnt==0, go to FIX; else decrement cnt.
  - Exactly XLEN CALC cycles.
- State FIX:
  - quotient is negated when signed and sign_a != sign_b.
  - remainder is negated when signed and sign_a set.
  - res = quotient for DIV/DIVU, remainder for REM/REMU.
  - Next state DONE.
- State DONE: done=1 for exactly one cycle, res held; next state IDLE. res keeps its value until the next accept.
- Latency, normal path: accept at cycle 0, CALC cycles 1..XLEN, FIX at cycle XLEN+1, done at cycle XLEN+2. div_stall is high on cycles 0..XLEN+1 (34 cycles for XLEN=32).
- Latency, special cases: done at cycle 1; div_stall high for cycle 0 only.
- Start in DONE: start high during DONE belongs to the completing instruction and is not re-accepted. A back-to-back divide is accepted in the following IDLE cycle.
- flush: in any state, next state IDLE, busy=0, done=0, res unchanged. flush has priority over accept and over the DONE transition.
- Input stability: op_a, op_b and div_op are ignored outside the accept cycle; changes during CALC do not affect the result.
- load_hazard: has no effect once in CALC/FIX/DONE. In IDLE it blocks accept, and div_stall stays high because start=1.
- Arithmetic width: all arithmetic is modulo 2^XLEN except the XLEN+1-bit trial subtract. Negation is two's complement.

Test Plan:
- DIVU op_a=100, op_b=7, start held -> div_stall high 34 cycles, done on cycle 34, res=14; repeat as REMU -> res=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> res=0xFFFFFFFD (-3); REM same operands -> res=0xFFFFFFFF (-1); DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
- DIVU 5/0 -> done at cycle 1, res=0xFFFFFFFF; REMU 5/0 -> res=5; DIV 0x80000000/0xFFFFFFFF -> res=0x80000000; REM same -> res=0.
- Start DIVU 1000/10, assert flush at cycle 10 -> busy=0 next cycle, no done; then DIVU 20/3 -> res=6 at cycle 34 after its accept.
- start=1 with load_hazard=1 for 3 cycles, op_a changing, then load_hazard=0 with op_a=50, op_b=5, DIVU -> accepted only then, res=10; change op_b mid-CALC -> res still 10.
- nrst=0 during CALC cycle 15 -> next cycle state IDLE, res=0, busy=0, done=0; back-to-back DIVU 9/3 then REMU 9/4 -> res=3 then res=1, second accepted the cycle after the first done.

Source files
------------

// File: rtl/div_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : div_sequencer
//  Purpose  : Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU,
//             stalling the execute stage until the result is ready.
//  Revision : 1.0  initial release
// ============================================================================
module div_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            nrst,
    input  logic            flush,
    input  logic            load_hazard,
    input  logic            start,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] res,
    output logic            busy,
    output logic            done,
    output logic            div_stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0]  c_int_min  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(XLEN-1);

    state_t            r_state, w_next_state;
    logic [1:0]        r_op;
    logic              r_sign_a, r_sign_b;
    logic [XLEN-1:0]   r_b, r_rem, r_quo, r_res;
    logic [CNT_W-1:0]  r_cnt;

    // div_op[0]=0 selects the signed flavours (DIV/REM); div_op[1]=1 selects remainder
    logic              w_signed, w_neg_a, w_neg_b, w_accept, w_div_zero, w_ovf, w_special;
    logic [XLEN-1:0]   w_abs_a, w_abs_b, w_quo_fix, w_rem_fix;
    logic [XLEN:0]     w_trial;

    assign w_signed   = ~div_op[0];
    assign w_neg_a    = w_signed & op_a[XLEN-1];
    assign w_neg_b    = w_signed & op_b[XLEN-1];
    assign w_abs_a    = w_neg_a ? -op_a : op_a;
    assign w_abs_b    = w_neg_b ? -op_b : op_b;
    assign w_accept   = (r_state == S_IDLE) & start & ~load_hazard & ~flush;
    assign w_div_zero = (op_b == '0);
    assign w_ovf      = w_signed & (op_a == c_int_min) & (op_b == '1);
    assign w_special  = w_div_zero | w_ovf;

    assign w_trial    = {r_rem, r_quo[XLEN-1]} - {1'b0, r_b};
    assign w_quo_fix  = (~r_op[0] & (r_sign_a ^ r_sign_b)) ? -r_quo : r_quo;
    assign w_rem_fix  = (~r_op[0] & r_sign_a) ? -r_rem : r_rem;

    always_ff @(posedge CLK) begin
        if (!nrst) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = w_special ? S_DONE : S_CALC;
            S_CALC:  if (r_cnt == '0) w_next_state = S_FIX;
            S_FIX:   w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (flush) w_next_state = S_IDLE;
    end

    // Flush freezes the datapath; only the state register is redirected.
    always_ff @(posedge CLK) begin
        if (!nrst) begin
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
        end else if (!flush) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= div_op;
                        r_sign_a <= w_neg_a;
                        r_sign_b <= w_neg_b;
                        r_b      <= w_abs_b;
                        if (w_div_zero)
                            r_res <= div_op[1] ? op_a : '1;
                        else if (w_ovf)
                            r_res <= div_op[1] ? '0 : c_int_min;
                        else begin
                            r_rem <= '0;
                            r_quo <= w_abs_a;
                            r_cnt <= c_cnt_init;
                        end
                    end
                end
                S_CALC: begin
                    if (!w_trial[XLEN])
                        r_rem <= w_trial[XLEN-1:0];
                    else
                        r_rem <= {r_rem[XLEN-2:0], r_quo[XLEN-1]};
                    r_quo <= {r_quo[XLEN-2:0], ~w_trial[XLEN]};
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FIX: begin
                    r_res <= r_op[1] ? w_rem_fix : w_quo_fix;
                end
                default: ;
            endcase
        end
    end

    assign res       = r_res;
    assign busy      = (r_state == S_CALC) | (r_state == S_FIX);
    assign done      = (r_state == S_DONE);
    assign div_stall = start & ~done;

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_div_sequencer
//  Purpose  : Directed self-checking bench for div_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_sequencer;

    logic        CLK = 1'b0;
    logic        nrst, flush, load_hazard, start;
    logic [1:0]  div_op;
    logic [31:0] op_a, op_b;
    logic [31:0] res;
    logic        busy, done, div_stall;

    int n_pass = 0;
    int n_total = 0;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    div_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .CLK(CLK), .nrst(nrst), .flush(flush), .load_hazard(load_hazard),
        .start(start), .div_op(div_op), .op_a(op_a), .op_b(op_b),
        .res(res), .busy(busy), .done(done), .div_stall(div_stall)
    );

    always #5 CLK = ~CLK;

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        div_op = op;
        op_a   = a;
        op_b   = b;
    endtask

    // Called at a negedge; counts cycles from the current one until done is seen.
    task automatic wait_done(output int lat, output int stall, output logic [31:0] r);
        lat = -1; stall = 0; r = 'x;
        for (int n = 0; n < 100; n++) begin
            #1;
            if (done) begin
                lat = n;
                r = res;
                break;
            end
            if (div_stall) stall++;
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; flush = 1'b0; load_hazard = 1'b0; start = 1'b0;
        div_op = 2'b00; op_a = '0; op_b = '0;
        repeat (3) @(negedge CLK);
        #1;
        n_total++; if ({busy, done, div_stall} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {busy, done, div_stall}); else n_pass++;
        n_total++; if (res !== 32'h0) $display("FAIL reset_res: got %h expected 00000000", res); else n_pass++;
        nrst = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_normal();
        logic [31:0] vec_a [4] = '{32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] vec_b [4] = '{32'd7, 32'd7, 32'd2, 32'd2};
        logic [1:0]  vec_o [4] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] vec_r [4] = '{32'd14, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF};
        int lat, stall;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            issue(vec_o[i], vec_a[i], vec_b[i]);
            wait_done(lat, stall, r);
            start = 1'b0;
            n_total++; if (r !== vec_r[i]) $display("FAIL normal_res[%0d]: got %h expected %h", i, r, vec_r[i]); else n_pass++;
            n_total++; if (lat !== 34) $display("FAIL normal_lat[%0d]: got %0d expected 34", i, lat); else n_pass++;
            n_total++; if (stall !== 34) $display("FAIL normal_stall[%0d]: got %0d expected 34", i, stall); else n_pass++;
            @(negedge CLK);
        end
        issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
        wait_done(lat, stall, r);
        start = 1'b0;
        n_total++; if (r !== 32'hFFFFFFFD) $display("FAIL div_neg_b: got %h expected FFFFFFFD", r); else n_pass++;
        @(negedge CLK);
    endtask

    task automatic test_special();
        logic [31:0] vec_a [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] vec_b [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [1:0]  vec_o [4] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] vec_r [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
        int lat, stall;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            issue(vec_o[i], vec_a[i], vec_b[i]);
            wait_done(lat, stall, r);
            start = 1'b0;
            n_total++; if (r !== vec_r[i]) $display("FAIL special_res[%0d]: got %h expected %h", i, r, vec_r[i]); else n_pass++;
            n_total++; if (lat !== 1 || stall !== 1) $display("FAIL special_lat[%0d]: got lat %0d stall %0d expected 1/1", i, lat, stall); else n_pass++;
            @(negedge CLK);
        end
    endtask

    task automatic test_flush();
        int lat, stall, seen;
        logic [31:0] r;
        issue(OP_DIVU, 32'd1000, 32'd10);
        repeat (10) @(negedge CLK);
        flush = 1'b1;
        start = 1'b0;
        @(negedge CLK);
        flush = 1'b0;
        #1;
        n_total++; if ({busy, done} !== 2'b00) $display("FAIL flush_idle: got busy/done %b expected 00", {busy, done}); else n_pass++;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK); #1;
            if (done) seen++;
        end
        n_total++; if (seen !== 0) $display("FAIL flush_no_done: got %0d done pulses expected 0", seen); else n_pass++;
        @(negedge CLK);
        issue(OP_DIVU, 32'd20, 32'd3);
        wait_done(lat, stall, r);
        start = 1'b0;
        n_total++; if (r !== 32'd6 || lat !== 34) $display("FAIL flush_next: got res %h lat %0d expected 00000006 lat 34", r, lat); else n_pass++;
        @(negedge CLK);
    endtask

    task automatic test_load_hazard();
        int lat, stall;
        logic [31:0] r;
        load_hazard = 1'b1;
        for (int k = 0; k < 3; k++) begin
            issue(OP_DIVU, 32'd77 + 32'(k), 32'd5);
            #1;
            n_total++; if ({busy, div_stall} !== 2'b01) $display("FAIL hazard_hold[%0d]: got busy/stall %b expected 01", k, {busy, div_stall}); else n_pass++;
            @(negedge CLK);
        end
        load_hazard = 1'b0;
        issue(OP_DIVU, 32'd50, 32'd5);
        repeat (5) @(negedge CLK);
        op_b = 32'd1; op_a = 32'd999; div_op = OP_REM;
        wait_done(lat, stall, r);
        start = 1'b0;
        n_total++; if (r !== 32'd10) $display("FAIL hazard_res: got %h expected 0000000A", r); else n_pass++;
        n_total++; if (lat !== 29) $display("FAIL hazard_lat: got %0d expected 29", lat); else n_pass++;
        @(negedge CLK);
    endtask

    task automatic test_midreset();
        issue(OP_DIVU, 32'd1000, 32'd10);
        repeat (15) @(negedge CLK);
        #1;
        n_total++; if (busy !== 1'b1) $display("FAIL midreset_busy_before: got %b expected 1", busy); else n_pass++;
        nrst = 1'b0;
        start = 1'b0;
        @(negedge CLK);
        nrst = 1'b1;
        #1;
        n_total++; if ({busy, done} !== 2'b00 || res !== 32'h0) $display("FAIL midreset_state: got busy/done %b res %h expected 00 00000000", {busy, done}, res); else n_pass++;
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        int lat, stall;
        logic [31:0] r;
        issue(OP_DIVU, 32'd9, 32'd3);
        wait_done(lat, stall, r);
        n_total++; if (r !== 32'd3) $display("FAIL b2b_first: got %h expected 00000003", r); else n_pass++;
        issue(OP_REMU, 32'd9, 32'd4);
        @(negedge CLK); #1;
        n_total++; if ({busy, done, div_stall} !== 3'b001) $display("FAIL b2b_idle: got busy/done/stall %b expected 001", {busy, done, div_stall}); else n_pass++;
        @(negedge CLK); #1;
        n_total++; if (busy !== 1'b1) $display("FAIL b2b_accept: got busy %b expected 1", busy); else n_pass++;
        wait_done(lat, stall, r);
        start = 1'b0;
        n_total++; if (r !== 32'd1 || lat !== 33) $display("FAIL b2b_second: got res %h lat %0d expected 00000001 lat 33", r, lat); else n_pass++;
        @(negedge CLK);
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_normal();
        test_special();
        test_flush();
        test_load_hazard();
        test_midreset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
